// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single external memory port between the icache
// refill path and the dcache refill/write-back path. One fixed-length burst
// is in flight at a time; simultaneous requests are resolved round-robin.
//
// Handshakes:
//   - Command channel: mem_req is valid and mem_rdy is ready. A command beat
//     transfers on a cycle where both are high. While mem_req is high and
//     mem_rdy is low, mem_we, mem_addr and mem_wdata hold their values.
//   - Read data: mem_rvalid has no back-pressure. Every beat is forwarded in
//     the same cycle on rdata, qualified by the owner's i_rvalid or d_rvalid.
//   - Write data: d_wdata is always valid while a write-back is in progress.
//     d_wpop marks the cycle in which the current word was accepted by memory.
//   - Requests: i_req and d_req are levels held until the matching done pulse.
//     They are sampled only in IDLE.
module dmem_arbiter #(
  parameter int BEATS = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // icache refill path
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rvalid,
  output logic          i_done,
  // dcache refill / write-back path
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_wpop,
  output logic          d_rvalid,
  output logic          d_done,
  // shared read data
  output logic [31:0]   rdata,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_rdy,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  // The beat counter needs just enough bits to count 0..BEATS-1.
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Owner encoding, also used for the round-robin history.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR_BEAT = 2'd3
  } state_t;

  // Registered state
  state_t        state;
  logic          owner;
  logic          last_gnt;
  logic [AW-1:0] base;
  logic [CW-1:0] count;

  // Next-state values
  state_t        state_nx;
  logic          owner_nx;
  logic          last_gnt_nx;
  logic [AW-1:0] base_nx;
  logic [CW-1:0] count_nx;

  // Decoded events
  logic          gnt_any;
  logic          gnt_d;
  logic          rd_beat;
  logic          rd_last;
  logic          wr_accept;
  logic          wr_last;
  logic [AW-1:0] wr_addr;

  // Arbitration: a lone requester wins outright; on a tie the requester that
  // was not granted last time wins, so a fresh reset hands the first tie to
  // the dcache.
  always_comb begin
    gnt_any = i_req | d_req;
    gnt_d   = 1'b0;
    if (i_req && d_req) begin
      gnt_d = (last_gnt == OWN_I);
    end else if (d_req) begin
      gnt_d = 1'b1;
    end
  end

  // Beat qualification. A read beat counts in RD_DATA, and also in the RD_CMD
  // cycle that gets its command accepted, so fast memories may return beat 0
  // alongside the accept. Beats arriving in any other state are dropped.
  always_comb begin
    rd_beat   = mem_rvalid &&
                ((state == RD_DATA) || ((state == RD_CMD) && mem_rdy));
    rd_last   = rd_beat && (state == RD_DATA) && (count == LAST_BEAT);
    wr_accept = (state == WR_BEAT) && mem_rdy;
    wr_last   = wr_accept && (count == LAST_BEAT);
    // Burst address wraps modulo 2^AW; the low two base bits pass through.
    wr_addr   = base + AW'({count, 2'b00});
  end

  // State register and burst bookkeeping; reset abandons any burst silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_I;
      last_gnt <= OWN_I;
      base     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
      base     <= base_nx;
      count    <= count_nx;
    end
  end

  // Next-state and output decode; every output defaults to 0 so that IDLE
  // (and therefore reset) shows a fully quiet interface.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_gnt_nx = last_gnt;
    base_nx     = base;
    count_nx    = count;

    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_rvalid    = 1'b0;
    i_done      = 1'b0;
    d_rvalid    = 1'b0;
    d_done      = 1'b0;
    d_wpop      = 1'b0;
    rdata       = '0;

    unique case (state)
      IDLE: begin
        // Grant cycle only latches the burst; no bus activity yet.
        count_nx = '0;
        if (gnt_any) begin
          owner_nx    = gnt_d ? OWN_D : OWN_I;
          last_gnt_nx = gnt_d ? OWN_D : OWN_I;
          base_nx     = gnt_d ? d_addr : i_addr;
          state_nx    = (gnt_d && d_we) ? WR_BEAT : RD_CMD;
        end
      end

      RD_CMD: begin
        mem_req  = 1'b1;
        mem_addr = base;
        if (mem_rdy) begin
          state_nx = RD_DATA;
        end
        if (rd_beat) begin
          count_nx = count + 1'b1;
        end
      end

      RD_DATA: begin
        if (rd_beat) begin
          count_nx = count + 1'b1;
        end
        if (rd_last) begin
          count_nx = '0;
          state_nx = IDLE;
        end
      end

      WR_BEAT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = d_wdata;
        d_wpop    = wr_accept;
        d_done    = wr_last;
        if (wr_accept) begin
          count_nx = count + 1'b1;
        end
        if (wr_last) begin
          count_nx = '0;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Read data steering: same-cycle pass-through to the burst owner only.
    if (rd_beat) begin
      rdata = mem_rdata;
      if (owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_done   = rd_last;
      end else begin
        i_rvalid = 1'b1;
        i_done   = rd_last;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scenario tasks run in sequence, read
// beats and write beats are tracked through expected-value queues.
module tb_dmem_arbiter;

  localparam int BEATS = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_wpop;
  logic          d_rvalid;
  logic          d_done;
  logic [31:0]   rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rdy;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  int checks;
  int failures;

  logic [31:0] exp_q[$];   // expected read beat data
  logic [63:0] exp_wq[$];  // expected write beats {addr, data}

  dmem_arbiter #(.BEATS(BEATS), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rvalid   (i_rvalid),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wpop     (d_wpop),
    .d_rvalid   (d_rvalid),
    .d_done     (d_done),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next active edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    mem_rdy    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present one read beat from memory and record what the cache must see.
  task automatic drive_beat(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    exp_q.push_back(data);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n      = 1'b0;
    mem_rdy    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    i_req      = 1'b1;
    d_req      = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, i_done, d_rvalid,
         d_done, d_wpop, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h irv=%b idn=%b drv=%b ddn=%b pop=%b rd=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, i_done,
               d_rvalid, d_done, d_wpop, rdata);
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, i_rvalid, d_rvalid, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_idle_quiet: got req=%b irv=%b drv=%b rd=%h, want 0",
               mem_req, i_rvalid, d_rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_icache_read();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0100;
    mem_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL ird_grant_quiet: got mem_req=%b, want 0", mem_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      failures++;
      $display("FAIL ird_cmd: got req=%b we=%b addr=%h, want 1 0 00000100",
               mem_req, mem_we, mem_addr);
    end
    tick();
    // one idle cycle inside the burst
    mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, i_rvalid, i_done} !== 3'b000) begin
      failures++;
      $display("FAIL ird_gap: got req=%b irv=%b idn=%b, want 000",
               mem_req, i_rvalid, i_done);
    end
    tick();
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'hA0 + 32'(b));
      @(negedge clk);
      checks++;
      if ({i_rvalid, d_rvalid, d_done} !== 3'b100) begin
        failures++;
        $display("FAIL ird_beat%0d_valid: got irv=%b drv=%b ddn=%b, want 1 0 0",
                 b, i_rvalid, d_rvalid, d_done);
      end
      if (i_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL ird_beat%0d_data: got %h, want %h", b, rdata, e);
        end
      end
      checks++;
      if (i_done !== (b == BEATS - 1)) begin
        failures++;
        $display("FAIL ird_beat%0d_done: got %b, want %b", b, i_done, (b == BEATS - 1));
      end
      tick();
    end
    mem_rvalid = 1'b0;
    i_req      = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, i_rvalid, i_done} !== 3'b000) begin
      failures++;
      $display("FAIL ird_after_done: got req=%b irv=%b idn=%b, want 000",
               mem_req, i_rvalid, i_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ird_queue_empty: got %0d left, want 0", exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0200;
    mem_rdy = 1'b1;
    tick();  // grant cycle
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin
      failures++;
      $display("FAIL tie_first_dcache: got req=%b addr=%h, want 1 00000200", mem_req, mem_addr);
    end
    tick();
    mem_rdy = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'hD0 + 32'(b));
      @(negedge clk);
      checks++;
      if ({d_rvalid, i_rvalid, i_done, d_done} !== {2'b10, 1'b0, 1'(b == BEATS - 1)}) begin
        failures++;
        $display("FAIL tie_d_beat%0d: got drv=%b irv=%b idn=%b ddn=%b", b, d_rvalid, i_rvalid, i_done, d_done);
      end
      if (d_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL tie_d_data%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
    end
    mem_rvalid = 1'b0;
    d_req      = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL tie_gap_idle: got mem_req=%b, want 0", mem_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100}) begin
      failures++;
      $display("FAIL tie_icache_second: got req=%b addr=%h, want 1 00000100", mem_req, mem_addr);
    end
    mem_rdy = 1'b1;
    d_req   = 1'b1;
    d_addr  = 32'h0000_0240;
    tick();
    mem_rdy = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'hB0 + 32'(b));
      @(negedge clk);
      checks++;
      if ({i_rvalid, d_rvalid, i_done} !== {2'b10, 1'(b == BEATS - 1)}) begin
        failures++;
        $display("FAIL tie_i_beat%0d: got irv=%b drv=%b idn=%b", b, i_rvalid, d_rvalid, i_done);
      end
      if (i_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL tie_i_data%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
    end
    // both still requesting: icache was granted last, so dcache wins
    mem_rvalid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0240}) begin
      failures++;
      $display("FAIL tie_third_dcache: got req=%b addr=%h, want 1 00000240", mem_req, mem_addr);
    end
    i_req   = 1'b0;
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'hD4 + 32'(b));
      @(negedge clk);
      if (d_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL tie_d2_data%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
    end
    mem_rvalid = 1'b0;
    d_req      = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL tie_queue_empty: got %0d left, want 0", exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_write_backpressure();
    logic        pat  [6];
    logic [31:0] atab [6];
    int          idx;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    atab = '{32'h3FC, 32'h400, 32'h400, 32'h400, 32'h404, 32'h408};
    idx  = 0;
    for (int k = 0; k < BEATS; k++) begin
      exp_wq.push_back({32'h3FC + 32'(4 * k), 32'hC0DE_0000 + 32'(k)});
    end
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_03FC;
    d_wdata = 32'hC0DE_0000;
    @(negedge clk);
    checks++;
    if ({mem_req, d_wpop} !== 2'b00) begin
      failures++;
      $display("FAIL wr_grant_quiet: got req=%b pop=%b, want 00", mem_req, d_wpop);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      mem_rdy = pat[c];
      d_wdata = 32'hC0DE_0000 + 32'(idx);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, d_wpop, d_done} !==
          {2'b11, atab[c], pat[c], 1'(c == 5)}) begin
        failures++;
        $display("FAIL wr_cycle%0d: got req=%b we=%b addr=%h pop=%b done=%b, want 1 1 %h %b %b",
                 c, mem_req, mem_we, mem_addr, d_wpop, d_done, atab[c], pat[c], (c == 5));
      end
      if (d_wpop === 1'b1 && exp_wq.size() > 0) begin
        logic [63:0] e;
        e = exp_wq.pop_front();
        checks++;
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL wr_beat_data: got %h/%h, want %h/%h", mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
        idx++;
      end
      tick();
    end
    d_req   = 1'b0;
    d_we    = 1'b0;
    mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, d_wpop, d_done} !== 3'b000) begin
      failures++;
      $display("FAIL wr_after_done: got req=%b pop=%b done=%b, want 000", mem_req, d_wpop, d_done);
    end
    checks++;
    if (exp_wq.size() != 0) begin
      failures++;
      $display("FAIL wr_queue_empty: got %0d left, want 0", exp_wq.size());
    end
    exp_wq.delete();
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] atab [4];
    atab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    for (int k = 0; k < BEATS; k++) begin
      exp_wq.push_back({atab[k], 32'($urandom_range(0, 32'h7FFF_FFFF))});
    end
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'hFFFF_FFF8;
    mem_rdy = 1'b1;
    tick();  // grant
    for (int c = 0; c < BEATS; c++) begin
      d_wdata = exp_wq[0][31:0];
      @(negedge clk);
      checks++;
      if ({d_wpop, d_done} !== {1'b1, 1'(c == BEATS - 1)}) begin
        failures++;
        $display("FAIL wrap_ctl%0d: got pop=%b done=%b", c, d_wpop, d_done);
      end
      if (d_wpop === 1'b1 && exp_wq.size() > 0) begin
        logic [63:0] e;
        e = exp_wq.pop_front();
        checks++;
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL wrap_beat%0d: got %h/%h, want %h/%h", c, mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
      tick();
    end
    d_req   = 1'b0;
    d_we    = 1'b0;
    mem_rdy = 1'b0;
    checks++;
    if (exp_wq.size() != 0) begin
      failures++;
      $display("FAIL wrap_queue_empty: got %0d left, want 0", exp_wq.size());
    end
    exp_wq.delete();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0600;
    mem_rdy = 1'b1;
    tick();  // grant
    tick();  // command accepted
    mem_rdy = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0500;
    for (int b = 0; b < 3; b++) begin
      drive_beat(32'hF0 + 32'(b));
      @(negedge clk);
      if (i_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL rst_pre_beat%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
    end
    // the final beat is on the bus when reset hits between clock edges
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hF3;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, i_done, d_rvalid,
         d_done, d_wpop, rdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: got req=%b irv=%b idn=%b drv=%b rd=%h, want all 0",
               mem_req, i_rvalid, i_done, d_rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if ({i_rvalid, i_done, rdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_held: got irv=%b idn=%b rd=%h, want 0", i_rvalid, i_done, rdata);
    end
    tick();
    mem_rvalid = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    tick();  // grant with both requests held
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0500}) begin
      failures++;
      $display("FAIL rst_mid_regrant: got req=%b addr=%h, want 1 00000500", mem_req, mem_addr);
    end
    i_req   = 1'b0;
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'h50 + 32'(b));
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_done} !== {1'b1, 1'(b == BEATS - 1)}) begin
        failures++;
        $display("FAIL rst_post_beat%0d: got drv=%b ddn=%b", b, d_rvalid, d_done);
      end
      if (d_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL rst_post_data%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
    end
    mem_rvalid = 1'b0;
    d_req      = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_early_beat();
    // stray beat with nothing in flight
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    @(negedge clk);
    checks++;
    if ({i_rvalid, d_rvalid, rdata} !== '0) begin
      failures++;
      $display("FAIL stray_idle: got irv=%b drv=%b rd=%h, want 0", i_rvalid, d_rvalid, rdata);
    end
    tick();
    mem_rvalid = 1'b0;
    i_req      = 1'b1;
    i_addr     = 32'h0000_0700;
    tick();  // grant
    mem_rdy = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(32'hE0 + 32'(b));
      @(negedge clk);
      checks++;
      if ({i_rvalid, i_done} !== {1'b1, 1'(b == BEATS - 1)}) begin
        failures++;
        $display("FAIL early_beat%0d: got irv=%b idn=%b", b, i_rvalid, i_done);
      end
      if (i_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          failures++;
          $display("FAIL early_data%0d: got %h, want %h", b, rdata, e);
        end
      end
      tick();
      mem_rdy = 1'b0;
    end
    // stray beat right after done
    i_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h66;
    @(negedge clk);
    checks++;
    if ({i_rvalid, i_done, rdata} !== '0) begin
      failures++;
      $display("FAIL stray_after_done: got irv=%b idn=%b rd=%h, want 0", i_rvalid, i_done, rdata);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL early_queue_empty: got %0d left, want 0", exp_q.size());
    end
    exp_q.delete();
    tick();
    mem_rvalid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_icache_read();
    test_tie();
    test_write_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_early_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time so a stuck sequence still reports.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: run did not complete within 100000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
